// File: rtl/cordic_share_ctrl_pkg.sv
// Shared types and constants for the CORDIC sharing controller.
// The core width is fixed, so DATA_W lives here and not as a parameter.
package cordic_ctrl_pkg;

  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] NAN_VAL_DEF = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // LSB of requester i's operand inside the packed req_dataa bus
  function automatic int slice_lsb(input int i);
    return i * DATA_W;
  endfunction

endpackage

// File: rtl/cordic_share_ctrl_if.sv
// Requester and core-side signals of the shared CORDIC controller.
// slave = controller view, master = requesters plus core.
interface cordic_share_ctrl_if #(
  parameter int NUM_REQ = 4
);
  import cordic_ctrl_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_dataa;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]         rsp_result;
  logic                      rsp_err;
  logic                      core_clk_en;
  logic                      core_aclr;
  logic                      core_start;
  logic [DATA_W-1:0]         core_dataa;
  logic [DATA_W-1:0]         core_result;
  logic                      core_done;

  modport slave (
    input  req_valid, req_dataa, rsp_ready, core_result, core_done,
    output req_ready, rsp_valid, rsp_result, rsp_err,
           core_clk_en, core_aclr, core_start, core_dataa
  );

  modport master (
    output req_valid, req_dataa, rsp_ready, core_result, core_done,
    input  req_ready, rsp_valid, rsp_result, rsp_err,
           core_clk_en, core_aclr, core_start, core_dataa
  );

endinterface

// File: rtl/cordic_share_ctrl_arb.sv
// Combinational round-robin arbiter: the first requester after last wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic                       gnt_vld
);

  localparam int IDX_W = $clog2(NUM_REQ);

  int idx;

  // Scan from farthest to nearest, so the nearest request after last overwrites the rest
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = IDX_W'(idx);
        gnt_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_share_ctrl.sv
// Shares one multi-cycle cosine CORDIC core between NUM_REQ requesters.
// One operation is in flight at a time; a watchdog aborts a hung core.
module cordic_share_ctrl import cordic_ctrl_pkg::*; #(
  parameter int                NUM_REQ = 4,
  parameter int                TIMEOUT = 64,
  parameter logic [DATA_W-1:0] NAN_VAL = NAN_VAL_DEF
) (
  input  logic                clk,
  input  logic                reset,
  cordic_share_ctrl_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   last_grant, grant_reg, arb_idx;
  logic [NUM_REQ-1:0] arb_gnt;
  logic               arb_vld;
  logic [DATA_W-1:0]  op_reg, rsp_reg;
  logic               err_reg;
  logic               accept, done_hit, tmo_hit, rsp_take;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (bus.req_valid),
    .last    (last_grant),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  assign accept   = (state == IDLE) && arb_vld;
  assign done_hit = (state == BUSY) && bus.core_done;
  // cnt is about to step to TIMEOUT this cycle; done in the same cycle still wins
  assign tmo_hit  = (state == BUSY) && !bus.core_done && (cnt == CNT_W'(TIMEOUT - 1));
  assign rsp_take = (state == RESP) && bus.rsp_ready[grant_reg];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    bus.req_ready   = '0;
    bus.rsp_valid   = '0;
    bus.rsp_result  = '0;
    bus.rsp_err     = 1'b0;
    bus.core_clk_en = 1'b0;
    bus.core_start  = 1'b0;
    bus.core_dataa  = '0;
    bus.core_aclr   = reset;
    // Outputs are forced quiet while reset is high, even before state has been cleared
    if (!reset) begin
      case (state)
        IDLE: begin
          if (accept) begin
            bus.req_ready = arb_gnt;
            state_nxt     = START;
          end
        end
        START: begin
          bus.core_start  = 1'b1;
          bus.core_clk_en = 1'b1;
          bus.core_dataa  = op_reg;
          state_nxt       = BUSY;
        end
        BUSY: begin
          bus.core_clk_en = 1'b1;
          bus.core_dataa  = op_reg;
          bus.core_aclr   = tmo_hit;
          if (done_hit || tmo_hit) state_nxt = RESP;
        end
        RESP: begin
          bus.rsp_valid[grant_reg] = 1'b1;
          bus.rsp_result           = rsp_reg;
          bus.rsp_err              = err_reg;
          bus.core_dataa           = op_reg;
          if (rsp_take) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      grant_reg  <= '0;
      op_reg     <= '0;
      rsp_reg    <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (accept) begin
        op_reg    <= bus.req_dataa[slice_lsb(int'(arb_idx)) +: DATA_W];
        grant_reg <= arb_idx;
      end
      if (state == BUSY && cnt != CNT_W'(TIMEOUT)) cnt <= cnt + 1'b1;
      if (done_hit) begin
        rsp_reg <= bus.core_result;
        err_reg <= 1'b0;
      end else if (tmo_hit) begin
        rsp_reg <= NAN_VAL;
        err_reg <= 1'b1;
      end
      if (rsp_take) begin
        last_grant <= grant_reg;
        cnt        <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cordic_share_ctrl.sv
// Directed bench for cordic_share_ctrl with a behavioural CORDIC core stub.
module tb_cordic_share_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cordic_share_ctrl_if #(.NUM_REQ(4)) bus ();

  cordic_share_ctrl #(.NUM_REQ(4), .TIMEOUT(64), .NAN_VAL(32'h7FC00000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Core stub: done for one cycle lat cycles after start, result = dataa ^ A5A5A5A5; lat 0 = hang
  int   done_lat = 20;
  logic stub_busy;
  int   stub_cnt;
  always @(posedge clk) begin
    if (bus.core_aclr)                    begin stub_busy <= 1'b0; stub_cnt <= 0; end
    else if (bus.core_start)              begin stub_busy <= 1'b1; stub_cnt <= 1; end
    else if (bus.core_done)               stub_busy <= 1'b0;
    else if (stub_busy && bus.core_clk_en) stub_cnt <= stub_cnt + 1;
  end
  assign bus.core_done   = stub_busy && (done_lat != 0) && (stub_cnt == done_lat);
  assign bus.core_result = bus.core_dataa ^ 32'hA5A5A5A5;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit           rst_before;
    logic [3:0]   valid;
    logic [127:0] data;
    int           lat;
    int           exp_g;
    logic [31:0]  exp_res;
    logic         exp_err;
    int           exp_n;
    int           exp_aclr;
  } vec_t;

  localparam logic [127:0] DALL = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

  vec_t tbl [12];

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    bus.req_valid = '0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Waits for the accept pulse, then for the response, checking timing along the way
  task automatic run_op(input vec_t v, input int id);
    int n, aclr_n, start_n, en_n, rdy_n;
    bit got;
    logic [3:0] eg;
    logic [31:0] op;
    eg = 4'b0001 << v.exp_g;
    op = v.data[v.exp_g*32 +: 32];
    @(posedge clk); #1;
    bus.req_valid = v.valid;
    bus.req_dataa = v.data;
    bus.rsp_ready = 4'b1111;
    done_lat      = v.lat;
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      got = |bus.req_ready;
    end
    check($sformatf("op%0d accept", id), bus.req_ready, eg);
    @(negedge clk);
    check($sformatf("op%0d start", id), {bus.core_start, bus.core_dataa}, {1'b1, op});
    n = 0; aclr_n = 0; start_n = 0; rdy_n = 0; en_n = int'(bus.core_clk_en);
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      n++;
      aclr_n  += int'(bus.core_aclr);
      start_n += int'(bus.core_start);
      en_n    += int'(bus.core_clk_en);
      rdy_n   += int'(|bus.req_ready);
      got = |bus.rsp_valid;
    end
    check($sformatf("op%0d rsp_valid", id), bus.rsp_valid, eg);
    check($sformatf("op%0d rsp_result", id), bus.rsp_result, v.exp_res);
    check($sformatf("op%0d rsp_err", id), bus.rsp_err, v.exp_err);
    check($sformatf("op%0d latency", id), n, v.exp_n);
    check($sformatf("op%0d aclr pulses", id), aclr_n, v.exp_aclr);
    check($sformatf("op%0d clk_en cycles", id), en_n, v.exp_n);
    check($sformatf("op%0d extra start/ready", id), {start_n, rdy_n}, 64'd0);
    check($sformatf("op%0d dataa hold", id), bus.core_dataa, op);
  endtask

  logic [75:0] quiet;
  int bad_v, bad_r, bad_q;
  bit got;

  initial begin
    tbl[0]  = '{1'b1, 4'b0001, {96'h0, 32'h3E800000}, 20, 0, 32'h9B25A5A5, 1'b0, 21, 0};
    tbl[1]  = '{1'b1, 4'b1111, DALL, 20, 0, 32'hB4B4B4B4, 1'b0, 21, 0};
    tbl[2]  = '{1'b0, 4'b1111, DALL, 20, 1, 32'h87878787, 1'b0, 21, 0};
    tbl[3]  = '{1'b0, 4'b1111, DALL, 20, 2, 32'h96969696, 1'b0, 21, 0};
    tbl[4]  = '{1'b0, 4'b1111, DALL, 20, 3, 32'hE1E1E1E1, 1'b0, 21, 0};
    tbl[5]  = '{1'b0, 4'b1111, DALL, 20, 0, 32'hB4B4B4B4, 1'b0, 21, 0};
    tbl[6]  = '{1'b0, 4'b1111, DALL, 20, 1, 32'h87878787, 1'b0, 21, 0};
    tbl[7]  = '{1'b0, 4'b0100, DALL,  0, 2, 32'h7FC00000, 1'b1, 65, 1};
    tbl[8]  = '{1'b0, 4'b0100, DALL, 20, 2, 32'h96969696, 1'b0, 21, 0};
    tbl[9]  = '{1'b0, 4'b1000, DALL, 64, 3, 32'hE1E1E1E1, 1'b0, 65, 0};
    tbl[10] = '{1'b0, 4'b1010, DALL,  5, 1, 32'h87878787, 1'b0,  6, 0};
    tbl[11] = '{1'b0, 4'b0101, DALL,  1, 2, 32'h96969696, 1'b0,  2, 0};

    bus.req_valid = 4'b1111;
    bus.req_dataa = DALL;
    bus.rsp_ready = 4'b1111;

    // Outputs quiet under reset even with every requester valid
    repeat (2) begin
      @(negedge clk);
      quiet = {bus.req_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_err, bus.core_clk_en,
               bus.core_start, bus.core_dataa, bus.core_aclr};
      check("reset outputs", quiet, 76'd1);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    bus.req_valid = '0;

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].rst_before) do_reset();
      run_op(tbl[i], i);
    end

    // Response backpressure on requester 2 for 10 cycles
    @(posedge clk); #1;
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 4'b1011;
    done_lat = 20;
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin @(negedge clk); got = |bus.req_ready; end
    check("bp accept", bus.req_ready, 4'b0100);
    @(posedge clk); #1;
    bus.req_valid = 4'b1111;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin @(negedge clk); got = |bus.rsp_valid; end
    bad_v = 0; bad_r = 0; bad_q = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.rsp_valid !== 4'b0100) bad_v++;
      if (bus.rsp_result !== 32'h96969696 || bus.rsp_err !== 1'b0) bad_r++;
      if (bus.req_ready !== 4'b0000 || bus.core_start !== 1'b0) bad_q++;
    end
    check("bp rsp_valid held", bad_v, 0);
    check("bp rsp_result held", bad_r, 0);
    check("bp no accept/start", bad_q, 0);
    @(posedge clk); #1;
    bus.rsp_ready = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    check("bp next grant", bus.req_ready, 4'b1000);
    @(posedge clk); #1;
    bus.req_valid = '0;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin @(negedge clk); got = |bus.rsp_valid; end
    check("bp next rsp", {bus.rsp_valid, bus.rsp_result}, {4'b1000, 32'hE1E1E1E1});

    // Reset five cycles into BUSY: operation dropped, requester 0 first afterwards
    @(posedge clk); #1;
    bus.req_valid = 4'b0010;
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin @(negedge clk); got = |bus.req_ready; end
    check("rst accept", bus.req_ready, 4'b0010);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    check("rst start", bus.core_start, 1'b1);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      quiet = {bus.req_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_err, bus.core_clk_en,
               bus.core_start, bus.core_dataa, bus.core_aclr};
      check("mid-busy reset outputs", quiet, 76'd1);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post-reset grant", {bus.req_ready, bus.rsp_valid}, {4'b0001, 4'b0000});
    @(posedge clk); #1;
    bus.req_valid = '0;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin @(negedge clk); got = |bus.rsp_valid; end
    check("post-reset rsp", {bus.rsp_valid, bus.rsp_result}, {4'b0001, 32'hB4B4B4B4});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
